round_key_scheduler: RTL

//  Sequential AES-128 key-expansion controller. Loads a 128-bit cipher key, drives one

---
 rtl/round_key_scheduler_if.sv | 20 ++
 rtl/round_key_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/round_key_scheduler_if.sv
// Key-load and round-key read bus between the key source, the scheduler and the round datapath.
interface round_key_scheduler_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rd_idx,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/round_key_scheduler.sv
// AES-128 key expansion, one round per clock, into a bank of round keys with a
// combinational read port indexed by round number.
module round_key_scheduler #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic                   clk,
  input logic                   rst,
  round_key_scheduler_if.slave  bus
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
    8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
    8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
    8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
    8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
    8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
    8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
    8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
    8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
    8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
    8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
    8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    unique case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   rc_cnt_q, rc_cnt_d;
  logic         done_q, done_d;
  logic         keys_valid_q, keys_valid_d;
  logic [127:0] rk_q [NUM_ROUNDS+1];
  logic         accept;
  logic         last_round;
  logic [127:0] kg_in;
  logic [127:0] kg_out;
  logic [31:0]  kg_t;

  assign accept     = bus.start && (state_q != StExpand);
  assign last_round = (state_q == StExpand) && (rc_cnt_q == 4'(NUM_ROUNDS - 1));

  // Single KeyGeneration round: source key selected by the round counter.
  always_comb begin
    kg_in = '0;
    for (int i = 0; i < int'(NUM_ROUNDS); i++) begin
      if (rc_cnt_q == 4'(i)) kg_in = rk_q[i];
    end
    kg_t = sub_word({kg_in[23:0], kg_in[31:24]}) ^ {rcon(rc_cnt_q), 24'h0};
    kg_out[127:96] = kg_in[127:96] ^ kg_t;
    kg_out[95:64]  = kg_in[95:64]  ^ kg_out[127:96];
    kg_out[63:32]  = kg_in[63:32]  ^ kg_out[95:64];
    kg_out[31:0]   = kg_in[31:0]   ^ kg_out[63:32];
  end

  always_comb begin
    state_d      = state_q;
    rc_cnt_d     = rc_cnt_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (bus.start) begin
          state_d      = StExpand;
          rc_cnt_d     = 4'd0;
          keys_valid_d = 1'b0;
        end
      end
      StExpand: begin
        rc_cnt_d = rc_cnt_q + 4'd1;
        if (last_round) begin
          state_d      = StReady;
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rc_cnt_q     <= 4'd0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rc_cnt_q     <= rc_cnt_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= int'(NUM_ROUNDS); i++) rk_q[i] <= '0;
    end else begin
      if (accept) rk_q[0] <= bus.key_in;
      if (state_q == StExpand) begin
        for (int i = 1; i <= int'(NUM_ROUNDS); i++) begin
          if (rc_cnt_q == 4'(i - 1)) rk_q[i] <= kg_out;
        end
      end
    end
  end

  always_comb begin
    bus.rd_key = '0;
    for (int i = 0; i <= int'(NUM_ROUNDS); i++) begin
      if (bus.rd_idx == 4'(i)) bus.rd_key = rk_q[i];
    end
  end

  assign bus.busy       = (state_q == StExpand);
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;

endmodule
